// File: rtl/coord_pkg.sv
// Shared types and constants for the coordinate display reader.
package coord_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } coord_state_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_pair_t;

    localparam int DEPTH = 4;

    // Active-low segment patterns, gfedcba order
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/seg7_enc.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
module seg7_enc (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_on;

    // Table is written active-high and inverted on the way out
    always_comb begin
        seg_on = 7'h00;
        case (hex_i)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h67;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign seg_o = ~seg_on;

endmodule

// File: rtl/coord_display_reader.sv
// Buffers up to four (X,Y) pairs and cycles them on six seven-segment displays.
// Optional COORD_SUM_EN adds the x+y sum on H3 (low nibble) and H5 (carry).
module coord_display_reader
    import coord_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_valid,
    input  logic [3:0]   wr_x,
    input  logic [3:0]   wr_y,
    output logic         wr_ready,
    output logic [6:0]   H1,
    output logic [6:0]   H2,
    output logic [6:0]   H3,
    output logic [6:0]   H4,
    output logic [6:0]   H5,
    output logic [6:0]   H6,
    output coord_state_e dbg_state_o
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    // Handshake: a pair transfers on a rising edge where wr_valid && wr_ready.
    // wr_ready drops only when full, and a (0,0) clear is always accepted.
    coord_state_e  state_q, state_d;
    logic [1:0]    index_q, index_d;
    logic [2:0]    count_q, count_d;
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] dwell_q, dwell_d;
    coord_pair_t   mem_q [DEPTH];

    logic wr_is_zero, accept, do_clear, do_store;

    assign wr_is_zero = (wr_x == 4'd0) && (wr_y == 4'd0);
    assign wr_ready   = (count_q != 3'(DEPTH)) || wr_is_zero;
    assign accept     = wr_valid && wr_ready;
    assign do_clear   = accept && wr_is_zero;
    assign do_store   = accept && !wr_is_zero;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        dwell_d  = dwell_q;
        if (do_clear) begin
            state_d  = IDLE;
            index_d  = 2'd0;
            count_d  = 3'd0;
            wr_ptr_d = 2'd0;
            dwell_d  = '0;
        end else begin
            if (do_store) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
                count_d  = count_q + 3'd1;
            end
            case (state_q)
                IDLE: begin
                    if (do_store) begin
                        state_d = SHOW;
                        index_d = 2'd0;
                        dwell_d = '0;
                    end
                end
                SHOW: begin
                    // Wrap compares against the count held before this cycle's write
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        index_d = (({1'b0, index_q} + 3'd1) == count_q) ? 2'd0 : index_q + 2'd1;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            index_q  <= 2'd0;
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            dwell_q  <= dwell_d;
        end
    end

    // Buffer contents survive reset; count alone defines what is valid
    always_ff @(posedge clock) begin
        if (do_store) begin
            mem_q[wr_ptr_q] <= '{x: wr_x, y: wr_y};
        end
    end

    coord_pair_t cur;
    logic        show;
    logic [6:0]  seg_x, seg_y, seg_idx, seg_cnt;

    assign cur  = mem_q[index_q];
    assign show = (state_q == SHOW);

    seg7_enc u_enc_y   (.hex_i(cur.y),             .seg_o(seg_y));
    seg7_enc u_enc_x   (.hex_i(cur.x),             .seg_o(seg_x));
    seg7_enc u_enc_idx (.hex_i({2'b00, index_q}),  .seg_o(seg_idx));
    seg7_enc u_enc_cnt (.hex_i({1'b0, count_q}),   .seg_o(seg_cnt));

    logic [6:0] h1_d, h2_d, h3_d, h4_d, h5_d, h6_d;
    logic [6:0] h1_q, h2_q, h3_q, h4_q, h5_q, h6_q;

`ifdef COORD_SUM_EN
    logic [4:0] sum;
    logic [6:0] seg_slo, seg_shi;

    assign sum = {1'b0, cur.x} + {1'b0, cur.y};

    seg7_enc u_enc_slo (.hex_i(sum[3:0]),          .seg_o(seg_slo));
    seg7_enc u_enc_shi (.hex_i({3'b000, sum[4]}),  .seg_o(seg_shi));

    assign h3_d = show ? seg_slo : SEG_DASH;
    assign h5_d = show ? seg_shi : SEG_DASH;
`else
    assign h3_d = SEG_BLANK;
    assign h5_d = SEG_BLANK;
`endif

    // Index and count are both zero whenever the FSM is idle
    assign h1_d = show ? seg_y : SEG_DASH;
    assign h2_d = show ? seg_x : SEG_DASH;
    assign h4_d = seg_idx;
    assign h6_d = seg_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h1_q <= SEG_DASH;
            h2_q <= SEG_DASH;
            h3_q <= SEG_BLANK;
            h4_q <= 7'h40;
            h5_q <= SEG_BLANK;
            h6_q <= 7'h40;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
            h3_q <= h3_d;
            h4_q <= h4_d;
            h5_q <= h5_d;
            h6_q <= h6_d;
        end
    end

    assign H1          = h1_q;
    assign H2          = h2_q;
    assign H3          = h3_q;
    assign H4          = h4_q;
    assign H5          = h5_q;
    assign H6          = h6_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/coord_display_reader.md
# coord_display_reader

Read side of the coordinate-pair intake path. Accepts (X,Y) nibble pairs from the intake block over a valid/ready handshake and holds up to four in a small buffer. Cycles through the stored pairs on the six active-low seven-segment displays, dwelling on each for a fixed time. A (0,0) pair acts as a clear command and empties the buffer.

## Interface
- DWELL_CYCLES, 50_000_000, clock cycles each pair stays displayed (1 s at 50 MHz); minimum 2.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  intake offers a pair.
- wr_x  in  4  X coordinate.
- wr_y  in  4  Y coordinate.
- wr_ready  out  1  pair accepted on a rising edge when wr_valid && wr_ready.
- H1  out  7  Y of the displayed pair.
- H2  out  7  X of the displayed pair.
- H3  out  7  sum low nibble (see Configuration).
- H4  out  7  index of the displayed pair, 0–3.
- H5  out  7  sum carry (see Configuration).
- H6  out  7  stored pair count, 0–4.

All H outputs use segment order gfedcba and are active-low.

## Operation
- Buffer: 4 entries of {x,y}, a write pointer and `count` (0–4). Entries are never popped. They persist until a clear.
- wr_ready = (count != 4) || (wr_x == 0 && wr_y == 0). This is combinational, so a clear always passes, even when the buffer is full.
- When an accepted pair is (0,0), it is a clear: count←0, wr pointer←0, index←0, FSM→IDLE. Nothing is stored.
- When an accepted pair is non-zero, it is stored at the write pointer and count increments.
- FSM states:
  - IDLE (count==0): displays show dashes.
  - SHOW: displays show the entry at `index`.
- IDLE→SHOW on the first non-zero write. SHOW→IDLE only on a clear.
- Dwell counter, 0..DWELL_CYCLES-1:
  - Cleared on entry to SHOW and on every index advance.
  - When it reaches DWELL_CYCLES-1, index ← (index+1 == count) ? 0 : index+1.
  - The wrap uses the count value before any same-cycle write.
- With count==1, index stays at 0 and the counter keeps running.
- Writes arriving during SHOW do not disturb the index or the dwell counter.

## Timing
- All state and displays are registered. The displays reflect the state one cycle after it changes.
- First pair into an empty buffer: accepted at edge N, FSM is in SHOW at N, the pair is displayed from edge N+1.
- Index advance is visible one cycle after terminal count.
- Clear and dwell expiry in the same cycle: the clear wins, and index is 0.
- Reset value of every output, and the IDLE display:
  - H1 and H2: 7'h3F (dash).
  - H3 and H5: 7'h7F (blank).
  - H4 and H6: 7'h40 ("0").
  - wr_ready: 1.
- Reset may arrive mid-dwell. It returns the block to IDLE immediately (asynchronous). Buffer contents are not required to clear, but count is 0.

## Configuration
- COORD_SUM_EN defined:
  - Adds a 5-bit adder on the displayed pair, s = x + y.
  - H3 shows hex s[3:0]. H5 shows "1" if s[4] is set, otherwise "0".
  - In IDLE, H3 and H5 show dashes.
- COORD_SUM_EN undefined: no adder. H3 and H5 are constant 7'h7F.

## Structure
- Package coord_pkg holds:
  - The state enum {IDLE, SHOW}.
  - DEPTH = 4.
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F (both active-low).
- Sub-module seg7_enc: 4-bit hex in, 7-bit active-low segments out. It inverts the standard active-high table:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→67, A→77, B→7C, C→39, D→5E, E→79, F→71
- Instantiate seg7_enc once per numeric display.

## Test plan
Run the bench with DWELL_CYCLES=4.
- Reset released → H1=H2=7'h3F, H4=H6=7'h40, wr_ready=1.
- Write (3,5) → next cycle H2="3" (7'h30), H1="5" (7'h12), H6="1". Index stays 0 across 3 dwells.
- Write (1,2), (A,B), (F,F) → H6="4" and wr_ready=0 while (2,2) is offered. Index steps 0→1→2→3→0 every 4 cycles.
- With the buffer full, offer (0,0) → wr_ready=1, accepted. Next cycle shows IDLE dashes and H6="0".
- Clear on the same cycle as dwell expiry → index=0, IDLE. A following write (7,7) is displayed at index 0.
- With COORD_SUM_EN, pair (F,F) → H3="E", H5="1". Without it, H3=H5=7'h7F.
